// File: rtl/tube_issue_sched.sv
// Round-robin issue into a fixed-latency tube with tag-hazard blocking, an in-flight cap and a flush/drain sequence.
// Grant is combinational on req_ready, and issue_* is registered one cycle later. Requesters stall while hazarded, capped or draining.
module tube_issue_sched #(
  parameter int NUM_REQ      = 4,
  parameter int DEPTH        = 4,
  parameter int TAG_W        = 4,
  parameter int MAX_INFLIGHT = 5,
  localparam int SRC_W = $clog2(NUM_REQ),
  localparam int CNT_W = $clog2(DEPTH + 2)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*TAG_W-1:0] req_tag,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic                     flush,
  input  logic [DEPTH-1:0]         tube_valid,
  input  logic [DEPTH*TAG_W-1:0]   tube_tag,
  output logic                     issue_valid,
  output logic [SRC_W-1:0]         issue_src,
  output logic [TAG_W-1:0]         issue_tag,
  output logic [CNT_W-1:0]         inflight,
  output logic                     drain_done
);

  typedef enum logic {RUN, DRAIN} state_t;

  localparam logic [CNT_W-1:0] CAP = CNT_W'(MAX_INFLIGHT);

  state_t             state, state_nxt;
  logic               drain_done_nxt;
  logic [SRC_W-1:0]   rr_ptr, gnt_idx, idx, ptr_nxt;
  logic               gnt_any, open_gate;
  logic [NUM_REQ-1:0] hazard, elig;
  logic [CNT_W-1:0]   cnt;

  // The issue register holds an op the tracker has not captured yet, so it counts as in flight.
  always_comb begin
    cnt = CNT_W'(issue_valid);
    for (int k = 0; k < DEPTH; k++) cnt = cnt + CNT_W'(tube_valid[k]);
  end
  assign inflight = cnt;

  always_comb begin
    hazard = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (issue_valid && req_tag[i*TAG_W +: TAG_W] == issue_tag) hazard[i] = 1'b1;
      for (int k = 0; k < DEPTH; k++)
        if (tube_valid[k] && req_tag[i*TAG_W +: TAG_W] == tube_tag[k*TAG_W +: TAG_W])
          hazard[i] = 1'b1;
    end
  end

  assign open_gate = ~rst & (state == RUN) & ~flush & (inflight < CAP);
  assign elig      = req_valid & ~hazard & {NUM_REQ{open_gate}};

  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = rr_ptr;
    idx     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = SRC_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (!gnt_any && elig[idx]) begin
        gnt_any = 1'b1;
        gnt_idx = idx;
      end
    end
  end

  assign req_ready = gnt_any ? (NUM_REQ'(1) << gnt_idx) : '0;
  assign ptr_nxt   = (gnt_idx == SRC_W'(NUM_REQ - 1)) ? '0 : gnt_idx + SRC_W'(1);

  always_comb begin
    state_nxt      = state;
    drain_done_nxt = 1'b0;
    case (state)
      RUN:   if (flush) state_nxt = DRAIN;
      DRAIN: if (!issue_valid && tube_valid == '0) begin
        state_nxt      = RUN;
        drain_done_nxt = 1'b1;
      end
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= RUN;
      drain_done  <= 1'b0;
      issue_valid <= 1'b0;
      issue_src   <= '0;
      issue_tag   <= '0;
      rr_ptr      <= '0;
    end else begin
      state       <= state_nxt;
      drain_done  <= drain_done_nxt;
      issue_valid <= gnt_any;
      if (gnt_any) begin
        issue_src <= gnt_idx;
        issue_tag <= req_tag[gnt_idx*TAG_W +: TAG_W];
        rr_ptr    <= ptr_nxt;
      end
    end
  end

endmodule

// File: tb/tb_tube_issue_sched.sv
// Bench for tube_issue_sched: default instance for directed scheduling cases, plus a cap-2 instance.
module tb_tube_issue_sched;

  typedef struct packed {logic [1:0] src; logic [3:0] tag;} exp_t;

  logic        clk, rst;
  logic [3:0]  req_valid, req_ready, tube_valid;
  logic [15:0] req_tag, tube_tag;
  logic        flush, issue_valid, drain_done;
  logic [1:0]  issue_src;
  logic [3:0]  issue_tag;
  logic [2:0]  inflight;

  logic [3:0]  req_valid2, req_ready2, tube_valid2;
  logic [15:0] req_tag2, tube_tag2;
  logic        flush2, issue_valid2, drain_done2;
  logic [1:0]  issue_src2;
  logic [3:0]  issue_tag2;
  logic [2:0]  inflight2;

  logic        model1;
  int          n_tests = 0;
  int          n_fail  = 0;
  exp_t        q1[$], q2[$];
  exp_t        e1, e2;

  tube_issue_sched dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_tag(req_tag), .req_ready(req_ready),
    .flush(flush), .tube_valid(tube_valid), .tube_tag(tube_tag), .issue_valid(issue_valid),
    .issue_src(issue_src), .issue_tag(issue_tag), .inflight(inflight), .drain_done(drain_done)
  );

  tube_issue_sched #(.MAX_INFLIGHT(2)) dut2 (
    .clk(clk), .rst(rst), .req_valid(req_valid2), .req_tag(req_tag2), .req_ready(req_ready2),
    .flush(flush2), .tube_valid(tube_valid2), .tube_tag(tube_tag2), .issue_valid(issue_valid2),
    .issue_src(issue_src2), .issue_tag(issue_tag2), .inflight(inflight2), .drain_done(drain_done2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  // One clock; the tracker models capture issue_* as presented before the edge.
  task automatic tick();
    logic       pv1, pv2;
    logic [3:0] pt1, pt2;
    pv1 = issue_valid;  pt1 = issue_tag;
    pv2 = issue_valid2; pt2 = issue_tag2;
    @(posedge clk);
    #1;
    if (model1) begin
      tube_valid = {pv1, tube_valid[3:1]};
      tube_tag   = {pt1, tube_tag[15:4]};
    end
    tube_valid2 = {pv2, tube_valid2[3:1]};
    tube_tag2   = {pt2, tube_tag2[15:4]};
  endtask

  task automatic expect_grant(input string nm, input logic [3:0] exp_rdy,
                              input logic [1:0] src, input logic [3:0] tag);
    exp_t e;
    #1;
    chk(nm, 32'(req_ready), 32'(exp_rdy));
    if (exp_rdy != 4'b0000) begin
      e.src = src;
      e.tag = tag;
      q1.push_back(e);
    end
    tick();
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (issue_valid) begin
        if (q1.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL issue1_unexpected: got src=%0d tag=0x%0h, want no issue", issue_src, issue_tag);
        end else begin
          e1 = q1.pop_front();
          chk("issue1_src", 32'(issue_src), 32'(e1.src));
          chk("issue1_tag", 32'(issue_tag), 32'(e1.tag));
        end
      end
      if (issue_valid2) begin
        if (q2.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL issue2_unexpected: got src=%0d tag=0x%0h, want no issue", issue_src2, issue_tag2);
        end else begin
          e2 = q2.pop_front();
          chk("issue2_src", 32'(issue_src2), 32'(e2.src));
          chk("issue2_tag", 32'(issue_tag2), 32'(e2.tag));
        end
      end
      n_tests++;
      if (inflight2 > 3'd2) begin
        n_fail++;
        $display("FAIL inflight2_cap: got %0d, want <= 2", inflight2);
      end
    end
  end

  initial begin
    exp_t e;
    rst = 1'b1; req_valid = 4'hF; req_tag = 16'h3210; flush = 1'b0;
    tube_valid = 4'h0; tube_tag = 16'h0; model1 = 1'b0;
    req_valid2 = 4'h0; req_tag2 = 16'h0; flush2 = 1'b0; tube_valid2 = 4'h0; tube_tag2 = 16'h0;
    #2;
    chk("rst_issue_valid", 32'(issue_valid), 0);
    chk("rst_drain_done", 32'(drain_done), 0);
    chk("rst_req_ready", 32'(req_ready), 0);
    tick(); tick();
    rst = 1'b0;

    // Round robin over all four requesters, tube held empty.
    expect_grant("t2_g0", 4'b0001, 2'd0, 4'h0);
    expect_grant("t2_g1", 4'b0010, 2'd1, 4'h1);
    expect_grant("t2_g2", 4'b0100, 2'd2, 4'h2);
    expect_grant("t2_g3", 4'b1000, 2'd3, 4'h3);
    expect_grant("t2_g4", 4'b0001, 2'd0, 4'h0);
    req_valid = 4'h0;

    // Reset while an op sits in the issue register with rr_ptr at 2.
    req_valid = 4'b0010;
    expect_grant("t1_setup", 4'b0010, 2'd1, 4'h1);
    req_valid = 4'hF; req_tag = 16'h7654;
    #5;
    rst = 1'b1;
    #1;
    chk("t1_rst_issue_valid", 32'(issue_valid), 0);
    chk("t1_rst_issue_src", 32'(issue_src), 0);
    chk("t1_rst_issue_tag", 32'(issue_tag), 0);
    chk("t1_rst_req_ready", 32'(req_ready), 0);
    tick();
    rst = 1'b0;
    expect_grant("t1_after_rst", 4'b0001, 2'd0, 4'h4);
    req_valid = 4'h0;

    // Same tag back to back is blocked by the issue register.
    req_valid = 4'b0001; req_tag = 16'h0003;
    expect_grant("t4_req0", 4'b0001, 2'd0, 4'h3);
    req_valid = 4'b0010; req_tag = 16'h0030;
    expect_grant("t4_blocked", 4'b0000, 2'd0, 4'h0);
    expect_grant("t4_req1_free", 4'b0010, 2'd1, 4'h3);

    // Tube entry 2 holds tag 5: req0 waits, req1 proceeds.
    req_valid = 4'b0011; req_tag = 16'h0065;
    tube_valid = 4'b0100; tube_tag = 16'h0500;
    expect_grant("t3_req1", 4'b0010, 2'd1, 4'h6);
    req_valid = 4'b0001;
    expect_grant("t3_req0_hazard", 4'b0000, 2'd0, 4'h0);
    tube_valid = 4'b0000;
    expect_grant("t3_req0_retired", 4'b0001, 2'd0, 4'h5);
    req_valid = 4'h0; tube_tag = 16'h0;
    tick(); tick();

    // Flush with three ops in flight.
    model1 = 1'b1; tube_valid = 4'h0; tube_tag = 16'h0;
    req_valid = 4'hF; req_tag = 16'hBA98;
    expect_grant("t6_g1", 4'b0010, 2'd1, 4'h9);
    expect_grant("t6_g2", 4'b0100, 2'd2, 4'hA);
    expect_grant("t6_g3", 4'b1000, 2'd3, 4'hB);
    flush = 1'b1;
    #1;
    chk("t6_flush_no_grant", 32'(req_ready), 0);
    chk("t6_inflight3", 32'(inflight), 3);
    tick();
    flush = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk($sformatf("t6_drain_ready_c%0d", c), 32'(req_ready), 0);
      chk($sformatf("t6_drain_done_c%0d", c), 32'(drain_done), 0);
      tick();
    end
    #1;
    chk("t6_drain_done_pulse", 32'(drain_done), 1);
    expect_grant("t6_resume", 4'b0001, 2'd0, 4'h8);
    #1;
    chk("t6_drain_done_end", 32'(drain_done), 0);
    req_valid = 4'h0;
    repeat (7) tick();

    // Flush on an already-empty pipe.
    flush = 1'b1; req_valid = 4'b0100;
    #1;
    chk("t7_flush_no_grant", 32'(req_ready), 0);
    tick();
    flush = 1'b0;
    #1;
    chk("t7_drain_ready", 32'(req_ready), 0);
    chk("t7_drain_done_low", 32'(drain_done), 0);
    tick();
    #1;
    chk("t7_drain_done_pulse", 32'(drain_done), 1);
    expect_grant("t7_first_grant", 4'b0100, 2'd2, 4'hA);
    #1;
    chk("t7_drain_done_end", 32'(drain_done), 0);
    req_valid = 4'h0;

    // Cap of 2: each op occupies 5 cycles, so grants land on cycles 0,1,6,7,12,13.
    req_tag2 = 16'hBA98;
    for (int i = 0; i < 6; i++) begin
      e.src = 2'(i % 4);
      e.tag = 4'(8 + (i % 4));
      q2.push_back(e);
    end
    req_valid2 = 4'hF;
    #1;
    chk("t5_first_ready", 32'(req_ready2), 32'(4'b0001));
    repeat (16) tick();
    req_valid2 = 4'h0;
    repeat (8) tick();

    chk("q1_drained", 32'(q1.size()), 0);
    chk("q2_drained", 32'(q2.size()), 0);
    chk("dut2_no_drain_done", 32'(drain_done2), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
